// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the IF/ID, ID/EX and EX/MEM pipeline registers.
// Optional performance counters are built when HAZ_PERF_EN is defined.
module pipe_hazard_ctrl #(
  parameter int MD_LATENCY = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        ex_br_taken,
  input  logic        ex_jump,
  input  logic        ex_md_start,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_write,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        md_done,
`ifdef HAZ_PERF_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
`endif
  output logic        dbg_state
);

  localparam int CW = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;

  if (MD_LATENCY < 2) begin : g_bad_latency
    $error("pipe_hazard_ctrl: MD_LATENCY must be >= 2");
  end

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] md_cnt_q, md_cnt_d;
  logic          load_use;
  logic          redirect_evt;

  // Register 0 is hardwired, so a load targeting it can never create a hazard.
  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((id_uses_rs && (id_rs == ex_rt)) ||
                     (id_uses_rt && (id_rt == ex_rt)));

  assign dbg_state = state_q;

  always_comb begin
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    md_done      = 1'b0;
    redirect_evt = 1'b0;
    if (!rst) begin
      state_d     = RUN;
      md_cnt_d    = '0;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (ex_br_taken || ex_jump) begin
            redirect_evt = 1'b1;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
          end else if (ex_md_start) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_flush = 1'b1;
            md_cnt_d    = CW'(MD_LATENCY - 2);
            state_d     = MD_WAIT;
          end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
          end
        end
        MD_WAIT: begin
          if (md_cnt_q != '0) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_flush = 1'b1;
            md_cnt_d    = md_cnt_q - 1'b1;
          end else begin
            // Release cycle: the MD result leaves EX, so a load-use still applies.
            md_done = 1'b1;
            state_d = RUN;
            if (load_use) begin
              pc_write   = 1'b0;
              ifid_write = 1'b0;
              idex_flush = 1'b1;
            end
          end
        end
        default: begin
          state_d  = RUN;
          md_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q  <= state_d;
    md_cnt_q <= md_cnt_d;
  end

`ifdef HAZ_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
      if (redirect_evt && (flush_cnt != 32'hFFFF_FFFF)) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`else
  logic unused_redirect;
  assign unused_redirect = redirect_evt;
`endif

endmodule
